// File: rtl/regfile_sb.sv
// Register file with write-through bypass and per-register pending-write scoreboard.
// One storage cell per architectural register; the zero register gets no cell.

module regfile_sb_cell #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             claim,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            busy <= 1'b0;
        end else begin
            if (we) q <= wdata;
            // A claim in the same cycle as the writeback is a newer producer.
            if (claim)   busy <= 1'b1;
            else if (we) busy <= 1'b0;
        end
    end

endmodule

module regfile_sb #(
    parameter  int WIDTH    = 64,
    parameter  int DEPTH    = 32,
    parameter  int HAS_ZERO = 1,
    parameter  int ZERO_REG = 31,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    ReadRegister1,
    input  logic [AW-1:0]    ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    output logic             Busy1,
    output logic             Busy2,
    input  logic             RegWrite,
    input  logic [AW-1:0]    WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic             Claim,
    input  logic [AW-1:0]    ClaimRegister
);

    localparam int NUM_PORTS = 2;

    typedef struct packed {
        logic             en;
        logic [AW-1:0]    idx;
        logic [WIDTH-1:0] data;
    } wr_req_t;

    wr_req_t                               wr;
    logic                                  cl_en;
    logic [DEPTH-1:0][WIDTH-1:0]           regs;
    logic [DEPTH-1:0]                      busy;
    logic [NUM_PORTS-1:0][AW-1:0]          raddr;
    logic [NUM_PORTS-1:0][WIDTH-1:0]       rdata;
    logic [NUM_PORTS-1:0]                  rbusy;

    function automatic logic is_zero(input logic [AW-1:0] idx);
        return (HAS_ZERO != 0) && (idx == AW'(ZERO_REG));
    endfunction

    // Writes and claims to the zero register are squashed here, so bypass ignores them too.
    assign wr.en   = RegWrite && !is_zero(WriteRegister);
    assign wr.idx  = WriteRegister;
    assign wr.data = WriteData;
    assign cl_en   = Claim && !is_zero(ClaimRegister);

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_reg
            if (HAS_ZERO != 0 && i == ZERO_REG) begin : g_zero
                assign regs[i] = '0;
                assign busy[i] = 1'b0;
            end else begin : g_cell
                regfile_sb_cell #(.WIDTH(WIDTH)) u_cell (
                    .clk   (clk),
                    .rst_n (reset),
                    .we    (wr.en && wr.idx == AW'(i)),
                    .claim (cl_en && ClaimRegister == AW'(i)),
                    .wdata (wr.data),
                    .q     (regs[i]),
                    .busy  (busy[i])
                );
            end
        end
    endgenerate

    assign raddr[0] = ReadRegister1;
    assign raddr[1] = ReadRegister2;

    genvar p;
    generate
        for (p = 0; p < NUM_PORTS; p++) begin : g_port
            always_comb begin
                rdata[p] = regs[raddr[p]];
                rbusy[p] = busy[raddr[p]];
                if (wr.en && wr.idx == raddr[p]) begin
                    rdata[p] = wr.data;
                    rbusy[p] = 1'b0;
                end
            end
        end
    endgenerate

    assign ReadData1 = rdata[0];
    assign ReadData2 = rdata[1];
    assign Busy1     = rbusy[0];
    assign Busy2     = rbusy[1];

endmodule
